// File: rtl/execute_stage_if.sv
// Execute-stage bundle: ID/EX inputs, writeback forwarding inputs,
// pipeline control (stall/flush), branch resolution and EX/MEM outputs.
// The slave modport is the execute stage itself; master is the driver side.
interface execute_stage_if #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
);
    // pipeline control
    logic              stall;
    logic              flush;
    // ID/EX register contents
    logic [DATA_W-1:0] pc_e;
    logic [DATA_W-1:0] pc_plus2_e;
    logic [DATA_W-1:0] rd1_e;
    logic [DATA_W-1:0] rd2_e;
    logic [DATA_W-1:0] ext_e;
    logic [REG_AW-1:0] rs1_e;
    logic [REG_AW-1:0] rs2_e;
    logic [REG_AW-1:0] rd_e;
    logic              reg_write_e;
    logic              mem_write_e;
    logic              jump_e;
    logic              branch_e;
    logic              alu_src_e;
    logic [1:0]        result_src_e;
    logic [2:0]        alu_control_e;
    // writeback stage, used only for forwarding
    logic [DATA_W-1:0] result_w;
    logic [REG_AW-1:0] rd_w;
    logic              reg_write_w;
    // branch resolution back to fetch
    logic              pc_src_e;
    logic [DATA_W-1:0] pc_target_e;
    // EX/MEM register contents
    logic [DATA_W-1:0] alu_result_m;
    logic [DATA_W-1:0] write_data_m;
    logic [DATA_W-1:0] pc_plus2_m;
    logic [REG_AW-1:0] rd_m;
    logic              reg_write_m;
    logic              mem_write_m;
    logic [1:0]        result_src_m;

    modport slave (
        input  stall, flush,
        input  pc_e, pc_plus2_e, rd1_e, rd2_e, ext_e, rs1_e, rs2_e, rd_e,
        input  reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e,
        input  result_src_e, alu_control_e,
        input  result_w, rd_w, reg_write_w,
        output pc_src_e, pc_target_e,
        output alu_result_m, write_data_m, pc_plus2_m, rd_m,
        output reg_write_m, mem_write_m, result_src_m
    );

    modport master (
        output stall, flush,
        output pc_e, pc_plus2_e, rd1_e, rd2_e, ext_e, rs1_e, rs2_e, rd_e,
        output reg_write_e, mem_write_e, jump_e, branch_e, alu_src_e,
        output result_src_e, alu_control_e,
        output result_w, rd_w, reg_write_w,
        input  pc_src_e, pc_target_e,
        input  alu_result_m, write_data_m, pc_plus2_m, rd_m,
        input  reg_write_m, mem_write_m, result_src_m
    );
endinterface

// File: rtl/execute_stage.sv
// Execute stage of the 16-bit pipelined processor.
// Selects ALU operands, runs the ALU, resolves branch/jump for the fetch PC
// mux and holds results in the EX/MEM register.
// Optional feature: define EXE_FWD_EN to bypass EX/MEM and writeback results
// into the ALU operands; without it the operands come straight from ID/EX.
// Reset is synchronous and active-low on port rst.
module execute_stage #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 4
) (
    input  logic         clk,
    input  logic         rst,
    execute_stage_if.slave bus
);

    typedef struct packed {
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] write_data;
        logic [DATA_W-1:0] pc_plus2;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              mem_write;
        logic [1:0]        result_src;
    } exmem_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLL = 3'b101,
        ALU_SRL = 3'b110,
        ALU_SLT = 3'b111
    } alu_op_e;

    exmem_t            exmem_q;
    exmem_t            exmem_d;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] src_b;
    logic [DATA_W-1:0] alu_result;
    logic              zero;
    alu_op_e           alu_op;

`ifdef EXE_FWD_EN
    // Operand bypass: the younger EX/MEM result wins over writeback.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        op_a = bus.rd1_e;
        op_b = bus.rd2_e;
        if (exmem_q.reg_write && (exmem_q.rd == bus.rs1_e)) begin
            op_a = exmem_q.alu_result;
        end else if (bus.reg_write_w && (bus.rd_w == bus.rs1_e)) begin
            op_a = bus.result_w;
        end
        if (exmem_q.reg_write && (exmem_q.rd == bus.rs2_e)) begin
            op_b = exmem_q.alu_result;
        end else if (bus.reg_write_w && (bus.rd_w == bus.rs2_e)) begin
            op_b = bus.result_w;
        end
    end
`else
    // Without bypass the hazard unit/software guarantees fresh ID/EX operands;
    // the forwarding inputs stay on the bundle for a fixed interface.
    logic fwd_unused;
    assign fwd_unused = ^{bus.rs1_e, bus.rs2_e, bus.result_w, bus.rd_w, bus.reg_write_w};
    assign op_a = bus.rd1_e;
    assign op_b = bus.rd2_e;
`endif

    assign src_b  = bus.alu_src_e ? bus.ext_e : op_b;
    assign alu_op = alu_op_e'(bus.alu_control_e);

    // ALU, all results modulo 2^DATA_W; shifts use the low four bits of B.
    always_comb begin
        alu_result = '0;
        case (alu_op)
            ALU_ADD: alu_result = op_a + src_b;
            ALU_SUB: alu_result = op_a - src_b;
            ALU_AND: alu_result = op_a & src_b;
            ALU_OR:  alu_result = op_a | src_b;
            ALU_XOR: alu_result = op_a ^ src_b;
            ALU_SLL: alu_result = op_a << src_b[3:0];
            ALU_SRL: alu_result = op_a >> src_b[3:0];
            ALU_SLT: alu_result = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(src_b))};
            default: alu_result = '0;
        endcase
    end

    assign zero = (alu_result == '0);

    // Branch/jump resolution is same-cycle; redirect is suppressed in reset.
    assign bus.pc_target_e = bus.pc_e + (bus.ext_e << 1);
    assign bus.pc_src_e    = rst & (bus.jump_e | (bus.branch_e & zero));

    // EX/MEM next state: flush loads a bubble, stall holds, otherwise load.
    always_comb begin
        exmem_d = exmem_q;
        if (bus.flush) begin
            exmem_d = '0;
        end else if (!bus.stall) begin
            exmem_d.alu_result = alu_result;
            exmem_d.write_data = op_b;
            exmem_d.pc_plus2   = bus.pc_plus2_e;
            exmem_d.rd         = bus.rd_e;
            exmem_d.reg_write  = bus.reg_write_e;
            exmem_d.mem_write  = bus.mem_write_e;
            exmem_d.result_src = bus.result_src_e;
        end
    end

    // EX/MEM register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
        if (!rst) begin
            exmem_q <= '0;
        end else begin
            exmem_q <= exmem_d;
        end
    end

    assign bus.alu_result_m = exmem_q.alu_result;
    assign bus.write_data_m = exmem_q.write_data;
    assign bus.pc_plus2_m   = exmem_q.pc_plus2;
    assign bus.rd_m         = exmem_q.rd;
    assign bus.reg_write_m  = exmem_q.reg_write;
    assign bus.mem_write_m  = exmem_q.mem_write;
    assign bus.result_src_m = exmem_q.result_src;

endmodule

// File: tb/tb_execute_stage.sv
// Directed self-checking bench for execute_stage (both EXE_FWD_EN builds).
module tb_execute_stage;

    logic clk;
    logic rst;
    int   checks;
    int   fails;

    execute_stage_if #(.DATA_W(16), .REG_AW(4)) bus ();

    execute_stage #(.DATA_W(16), .REG_AW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.stall         = 1'b0;
        bus.flush         = 1'b0;
        bus.pc_e          = 16'h0000;
        bus.pc_plus2_e    = 16'h0000;
        bus.rd1_e         = 16'h0000;
        bus.rd2_e         = 16'h0000;
        bus.ext_e         = 16'h0000;
        bus.rs1_e         = 4'hE;
        bus.rs2_e         = 4'hE;
        bus.rd_e          = 4'h0;
        bus.reg_write_e   = 1'b0;
        bus.mem_write_e   = 1'b0;
        bus.jump_e        = 1'b0;
        bus.branch_e      = 1'b0;
        bus.alu_src_e     = 1'b0;
        bus.result_src_e  = 2'b00;
        bus.alu_control_e = 3'b000;
        bus.result_w      = 16'h0000;
        bus.rd_w          = 4'h0;
        bus.reg_write_w   = 1'b0;
    endtask

    task automatic random_inputs();
        bus.stall         = 1'($urandom_range(0, 1));
        bus.flush         = 1'($urandom_range(0, 1));
        bus.pc_e          = 16'($urandom);
        bus.pc_plus2_e    = 16'($urandom);
        bus.rd1_e         = 16'($urandom);
        bus.rd2_e         = 16'($urandom);
        bus.ext_e         = 16'($urandom);
        bus.rs1_e         = 4'($urandom);
        bus.rs2_e         = 4'($urandom);
        bus.rd_e          = 4'($urandom_range(1, 15));
        bus.reg_write_e   = 1'b1;
        bus.mem_write_e   = 1'b1;
        bus.jump_e        = 1'b1;
        bus.branch_e      = 1'($urandom_range(0, 1));
        bus.alu_src_e     = 1'($urandom_range(0, 1));
        bus.result_src_e  = 2'($urandom_range(1, 3));
        bus.alu_control_e = 3'($urandom);
        bus.result_w      = 16'($urandom);
        bus.rd_w          = 4'($urandom);
        bus.reg_write_w   = 1'($urandom_range(0, 1));
    endtask

    task automatic check_exmem_zero(input string tag);
        check({tag, ".alu_result_m"}, 32'(bus.alu_result_m), 32'h0);
        check({tag, ".write_data_m"}, 32'(bus.write_data_m), 32'h0);
        check({tag, ".pc_plus2_m"},   32'(bus.pc_plus2_m),   32'h0);
        check({tag, ".rd_m"},         32'(bus.rd_m),         32'h0);
        check({tag, ".reg_write_m"},  32'(bus.reg_write_m),  32'h0);
        check({tag, ".mem_write_m"},  32'(bus.mem_write_m),  32'h0);
        check({tag, ".result_src_m"}, 32'(bus.result_src_m), 32'h0);
    endtask

    initial begin
        checks = 0;
        fails  = 0;

        // Reset held two cycles with random inputs (jump forced high).
        rst = 1'b0;
        random_inputs();
        step();
        check_exmem_zero("rst_c1");
        check("rst_c1.pc_src_e", 32'(bus.pc_src_e), 32'h0);
        random_inputs();
        step();
        check_exmem_zero("rst_c2");
        check("rst_c2.pc_src_e", 32'(bus.pc_src_e), 32'h0);

        // Add with overflow into the sign bit.
        rst = 1'b1;
        clear_inputs();
        bus.rd1_e        = 16'h7FFF;
        bus.rd2_e        = 16'h0001;
        bus.rd_e         = 4'd3;
        bus.reg_write_e  = 1'b1;
        bus.pc_plus2_e   = 16'h0022;
        bus.result_src_e = 2'b01;
        step();
        check("add.alu_result_m", 32'(bus.alu_result_m), 32'h8000);
        check("add.rd_m",         32'(bus.rd_m),         32'h3);
        check("add.reg_write_m",  32'(bus.reg_write_m),  32'h1);
        check("add.write_data_m", 32'(bus.write_data_m), 32'h0001);
        check("add.pc_plus2_m",   32'(bus.pc_plus2_m),   32'h0022);
        check("add.result_src_m", 32'(bus.result_src_m), 32'h1);

        // Branch taken / not taken, jump, target arithmetic and wrap.
        clear_inputs();
        bus.branch_e      = 1'b1;
        bus.rd1_e         = 16'h0055;
        bus.rd2_e         = 16'h0055;
        bus.alu_control_e = 3'b001;
        bus.pc_e          = 16'h0010;
        bus.ext_e         = 16'h0004;
        #1;
        check("beq_taken.pc_src_e",    32'(bus.pc_src_e),    32'h1);
        check("beq_taken.pc_target_e", 32'(bus.pc_target_e), 32'h0018);
        bus.rd2_e = 16'h0056;
        #1;
        check("beq_not.pc_src_e", 32'(bus.pc_src_e), 32'h0);
        bus.jump_e = 1'b1;
        #1;
        check("jump.pc_src_e", 32'(bus.pc_src_e), 32'h1);
        bus.ext_e = 16'hFFFE;
        #1;
        check("target_neg.pc_target_e", 32'(bus.pc_target_e), 32'h000C);
        bus.pc_e  = 16'hFFFE;
        bus.ext_e = 16'h0002;
        #1;
        check("target_wrap.pc_target_e", 32'(bus.pc_target_e), 32'h0002);
        step();
        check("sub.alu_result_m", 32'(bus.alu_result_m), 32'hFFFF);

        // Remaining ALU operations.
        clear_inputs();
        bus.alu_control_e = 3'b111;
        bus.rd1_e         = 16'hFFFF;
        bus.rd2_e         = 16'h0001;
        step();
        check("slt_true.alu_result_m", 32'(bus.alu_result_m), 32'h0001);
        bus.rd1_e = 16'h0001;
        bus.rd2_e = 16'hFFFF;
        step();
        check("slt_false.alu_result_m", 32'(bus.alu_result_m), 32'h0000);
        bus.alu_control_e = 3'b110;
        bus.rd1_e         = 16'h8000;
        bus.rd2_e         = 16'h1234;
        bus.alu_src_e     = 1'b1;
        bus.ext_e         = 16'h000F;
        step();
        check("srl_imm.alu_result_m", 32'(bus.alu_result_m), 32'h0001);
        check("srl_imm.write_data_m", 32'(bus.write_data_m), 32'h1234);
        bus.alu_src_e     = 1'b0;
        bus.alu_control_e = 3'b101;
        bus.rd1_e         = 16'h0001;
        bus.rd2_e         = 16'h0013;
        step();
        check("sll.alu_result_m", 32'(bus.alu_result_m), 32'h0008);
        bus.rd1_e         = 16'hF0F0;
        bus.rd2_e         = 16'h0FF0;
        bus.alu_control_e = 3'b010;
        step();
        check("and.alu_result_m", 32'(bus.alu_result_m), 32'h00F0);
        bus.alu_control_e = 3'b011;
        step();
        check("or.alu_result_m", 32'(bus.alu_result_m), 32'hFFF0);
        bus.alu_control_e = 3'b100;
        step();
        check("xor.alu_result_m", 32'(bus.alu_result_m), 32'hFF00);

        // Stall holds EX/MEM; stall+flush loads a bubble.
        clear_inputs();
        bus.rd1_e        = 16'h1111;
        bus.rd2_e        = 16'h2222;
        bus.rd_e         = 4'd5;
        bus.reg_write_e  = 1'b1;
        bus.mem_write_e  = 1'b1;
        bus.result_src_e = 2'b10;
        step();
        check("load.alu_result_m", 32'(bus.alu_result_m), 32'h3333);
        bus.stall       = 1'b1;
        bus.rd1_e       = 16'h0F00;
        bus.rd_e        = 4'd7;
        bus.mem_write_e = 1'b0;
        bus.jump_e      = 1'b1;
        step();
        check("stall.alu_result_m", 32'(bus.alu_result_m), 32'h3333);
        check("stall.rd_m",         32'(bus.rd_m),         32'h5);
        check("stall.mem_write_m",  32'(bus.mem_write_m),  32'h1);
        check("stall.result_src_m", 32'(bus.result_src_m), 32'h2);
        check("stall.pc_src_e",     32'(bus.pc_src_e),     32'h1);
        bus.flush = 1'b1;
        step();
        check_exmem_zero("stall_flush");

        // Reset mid-stream discards the in-flight instruction.
        clear_inputs();
        bus.rd1_e       = 16'h0042;
        bus.rd_e        = 4'd9;
        bus.reg_write_e = 1'b1;
        rst = 1'b0;
        step();
        check("rst_mid.alu_result_m", 32'(bus.alu_result_m), 32'h0);
        check("rst_mid.reg_write_m",  32'(bus.reg_write_m),  32'h0);
        rst = 1'b1;

        // Back-to-back dependency: r2 = 5, then r6 = r2 + r2 (stale ID/EX 0).
        clear_inputs();
        bus.rd1_e       = 16'h0005;
        bus.rd_e        = 4'd2;
        bus.reg_write_e = 1'b1;
        step();
        check("fwd_prod.alu_result_m", 32'(bus.alu_result_m), 32'h0005);
        bus.rd1_e       = 16'h0000;
        bus.rs1_e       = 4'd2;
        bus.rs2_e       = 4'd2;
        bus.rd_e        = 4'd6;
        bus.reg_write_w = 1'b1;
        bus.rd_w        = 4'd2;
        bus.result_w    = 16'h0100;
        step();
`ifdef EXE_FWD_EN
        check("fwd_mem.alu_result_m", 32'(bus.alu_result_m), 32'h000A);
        check("fwd_mem.write_data_m", 32'(bus.write_data_m), 32'h0005);
`else
        check("nofwd_mem.alu_result_m", 32'(bus.alu_result_m), 32'h0000);
        check("nofwd_mem.write_data_m", 32'(bus.write_data_m), 32'h0000);
`endif
        // EX/MEM now holds r6; r2 only matches in writeback.
        bus.rs2_e = 4'd7;
        bus.rd2_e = 16'h0003;
        bus.rd_e  = 4'd8;
        step();
`ifdef EXE_FWD_EN
        check("fwd_wb.alu_result_m", 32'(bus.alu_result_m), 32'h0103);
`else
        check("nofwd_wb.alu_result_m", 32'(bus.alu_result_m), 32'h0003);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
